hamming_byte_encoder_ctrl: RTL and testbench



---
 rtl/hamming_pkg.sv | 23 ++
 rtl/hamming_byte_encoder_ctrl_if.sv | 34 +++
 rtl/hamming_encoder_table.sv | 41 ++++
 rtl/hamming_byte_encoder_ctrl.sv | 116 +++++++++++
 tb/tb_hamming_byte_encoder_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_pkg
//  Description : Shared types and constants for the Hamming byte encoder
//                controller and its codeword lookup table.
//  Revision    : 1.0  initial release
// ============================================================================
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } enc_state_t;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] codeword_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/hamming_byte_encoder_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_byte_encoder_ctrl_if
//  Description : Byte request channels (A, B) and the codeword output stream.
//                master = byte producers / downstream sink side,
//                slave  = encoder controller side.
//  Revision    : 1.0  initial release
// ============================================================================
interface hamming_byte_encoder_ctrl_if;

    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] cw_data;
    logic       cw_valid;
    logic       cw_ready;
    logic       cw_src;
    logic       cw_last;

    modport master (
        output a_data, a_valid, b_data, b_valid, cw_ready,
        input  a_ready, b_ready, cw_data, cw_valid, cw_src, cw_last
    );

    modport slave (
        input  a_data, a_valid, b_data, b_valid, cw_ready,
        output a_ready, b_ready, cw_data, cw_valid, cw_src, cw_last
    );

endinterface
`default_nettype wire

// File: rtl/hamming_encoder_table.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_encoder_table
//  Description : 4-bit to 8-bit extended Hamming (8,4,4) codeword lookup.
//                Codewords are the linear code XORed with a fixed 8'h15
//                pattern, so an all-zero nibble never yields an all-zero line.
//  Revision    : 1.0  initial release
// ============================================================================
module hamming_encoder_table
    import hamming_pkg::*;
(
    input  nibble_t   nibble_i,
    output codeword_t code_o
);

    // Pure combinational table lookup
    always_comb begin
        code_o = 8'h15;
        case (nibble_i)
            4'h0: code_o = 8'h15;
            4'h1: code_o = 8'h02;
            4'h2: code_o = 8'h49;
            4'h3: code_o = 8'h5E;
            4'h4: code_o = 8'h64;
            4'h5: code_o = 8'h73;
            4'h6: code_o = 8'h38;
            4'h7: code_o = 8'h2F;
            4'h8: code_o = 8'hD0;
            4'h9: code_o = 8'hC7;
            4'hA: code_o = 8'h8C;
            4'hB: code_o = 8'h9B;
            4'hC: code_o = 8'hA1;
            4'hD: code_o = 8'hB6;
            4'hE: code_o = 8'hFD;
            4'hF: code_o = 8'hEA;
            default: code_o = 8'h15;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hamming_byte_encoder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_byte_encoder_ctrl
//  Description : Round-robin arbiter between two byte requesters feeding one
//                shared Hamming table; each accepted byte leaves as two
//                codewords (high nibble, then low nibble) on a valid/ready
//                stream tagged with source and last flags.
//  Revision    : 1.0  initial release
// ============================================================================
module hamming_byte_encoder_ctrl
    import hamming_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    hamming_byte_encoder_ctrl_if.slave  bus,
    output logic [COUNT_W-1:0]          cw_count,
    output logic                        busy
);

    enc_state_t          state_q;
    logic                last_grant_q;
    nibble_t             lo_nib_q;
    codeword_t           cw_data_q;
    logic                cw_valid_q;
    logic                cw_src_q;
    logic                cw_last_q;
    logic [COUNT_W-1:0]  count_q;

    logic                w_take_point;
    logic                w_take;
    logic                w_src;
    codeword_t           w_byte;
    nibble_t             w_enc_in;
    codeword_t           w_enc_out;

    // Arbitration and accept decision; reset suppresses any take so no ready
    // leaks out in a cycle whose state is about to be discarded
    always_comb begin
        w_take_point = !reset &&
                       ((state_q == IDLE) || ((state_q == SEND_LO) && bus.cw_ready));
        if (bus.a_valid && bus.b_valid) begin
            w_src = (last_grant_q == SRC_A) ? SRC_B : SRC_A;
        end else if (bus.b_valid) begin
            w_src = SRC_B;
        end else begin
            w_src = SRC_A;
        end
        w_take   = w_take_point && (bus.a_valid || bus.b_valid);
        w_byte   = (w_src == SRC_B) ? bus.b_data : bus.a_data;
        // One shared table: new high nibble on a take, else the latched low one
        w_enc_in = w_take ? w_byte[7:4] : lo_nib_q;
    end

    hamming_encoder_table u_table (
        .nibble_i (w_enc_in),
        .code_o   (w_enc_out)
    );

    // Sequencer: IDLE -> SEND_HI -> SEND_LO, with back-to-back takes from SEND_LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_B;
            lo_nib_q     <= '0;
            cw_data_q    <= '0;
            cw_valid_q   <= 1'b0;
            cw_src_q     <= SRC_A;
            cw_last_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            if (cw_valid_q && bus.cw_ready) begin
                count_q <= count_q + COUNT_W'(1);
            end
            if (w_take) begin
                last_grant_q <= w_src;
                lo_nib_q     <= w_byte[3:0];
                cw_src_q     <= w_src;
                cw_data_q    <= w_enc_out;
                cw_valid_q   <= 1'b1;
                cw_last_q    <= 1'b0;
                state_q      <= SEND_HI;
            end else begin
                case (state_q)
                    SEND_HI: begin
                        if (bus.cw_ready) begin
                            cw_data_q <= w_enc_out;
                            cw_last_q <= 1'b1;
                            state_q   <= SEND_LO;
                        end
                    end
                    SEND_LO: begin
                        if (bus.cw_ready) begin
                            cw_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.a_ready  = w_take && (w_src == SRC_A);
    assign bus.b_ready  = w_take && (w_src == SRC_B);
    assign bus.cw_data  = cw_data_q;
    assign bus.cw_valid = cw_valid_q;
    assign bus.cw_src   = cw_src_q;
    assign bus.cw_last  = cw_last_q;
    assign cw_count     = count_q;
    assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hamming_byte_encoder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamming_byte_encoder_ctrl
//  Description : Directed bench with a codeword scoreboard for the Hamming
//                byte encoder controller; a second instance with a 2-bit
//                counter shares the same stimulus to exercise wrap-around.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hamming_byte_encoder_ctrl;

    typedef struct packed {
        logic       src;
        logic       last;
        logic [7:0] data;
    } sb_t;

    logic        clk;
    logic        reset;
    logic [15:0] cnt_m;
    logic [1:0]  cnt_s;
    logic        busy_m;
    logic        busy_s;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int hs      = 0;
    sb_t  sb_q[$];
    logic hold_v = 1'b0;
    sb_t  hold_e;

    hamming_byte_encoder_ctrl_if bus_m ();
    hamming_byte_encoder_ctrl_if bus_s ();

    assign bus_s.a_data   = bus_m.a_data;
    assign bus_s.a_valid  = bus_m.a_valid;
    assign bus_s.b_data   = bus_m.b_data;
    assign bus_s.b_valid  = bus_m.b_valid;
    assign bus_s.cw_ready = bus_m.cw_ready;

    hamming_byte_encoder_ctrl #(.COUNT_W(16)) dut_m (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_m),
        .cw_count (cnt_m),
        .busy     (busy_m)
    );

    hamming_byte_encoder_ctrl #(.COUNT_W(2)) dut_s (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_s),
        .cw_count (cnt_s),
        .busy     (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Extended Hamming generator rows XOR the fixed 8'h15 pattern
    function automatic logic [7:0] enc_m(input logic [3:0] n);
        return 8'h15 ^ ({8{n[0]}} & 8'h17) ^ ({8{n[1]}} & 8'h5C)
                     ^ ({8{n[2]}} & 8'h71) ^ ({8{n[3]}} & 8'hC5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_byte(input logic src, input logic [7:0] b);
        sb_q.push_back('{src: src, last: 1'b0, data: enc_m(b[7:4])});
        sb_q.push_back('{src: src, last: 1'b1, data: enc_m(b[3:0])});
    endtask

    // Stream monitor: scoreboard pop, stall stability, counters, grant exclusivity
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            hs     = 0;
            hold_v = 1'b0;
        end else begin
            chk("cw_count", 32'(cnt_m), 32'(hs[15:0]));
            chk("cw_count_w2", 32'(cnt_s), 32'(hs[1:0]));
            chk("small_inst_match", {busy_s, bus_s.cw_valid, bus_s.cw_src, bus_s.cw_last, bus_s.cw_data},
                {busy_m, bus_m.cw_valid, bus_m.cw_src, bus_m.cw_last, bus_m.cw_data});
            if (bus_m.a_ready && bus_m.b_ready) chk("ready_excl", 32'd1, 32'd0);
            if (hold_v) begin
                chk("stall_hold", {bus_m.cw_valid, bus_m.cw_src, bus_m.cw_last, bus_m.cw_data},
                    {1'b1, hold_e});
            end
            if (bus_m.cw_valid && bus_m.cw_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_cw", {bus_m.cw_src, bus_m.cw_last, bus_m.cw_data}, 32'hFFFF);
                end else begin
                    chk("sb_codeword", {bus_m.cw_src, bus_m.cw_last, bus_m.cw_data}, sb_q.pop_front());
                end
                hs++;
            end
            hold_v = bus_m.cw_valid && !bus_m.cw_ready;
            hold_e = {bus_m.cw_src, bus_m.cw_last, bus_m.cw_data};
            if (bus_m.a_ready) push_byte(1'b0, bus_m.a_data);
            else if (bus_m.b_ready) push_byte(1'b1, bus_m.b_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] er [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        reset          = 1'b1;
        bus_m.a_data   = 8'h00;
        bus_m.a_valid  = 1'b0;
        bus_m.b_data   = 8'h00;
        bus_m.b_valid  = 1'b0;
        bus_m.cw_ready = 1'b1;

        // Reset state
        tick(); tick(); smp();
        chk("rst_outputs", {bus_m.cw_valid, bus_m.cw_src, bus_m.cw_last, bus_m.cw_data, busy_m},
            12'h000);
        chk("rst_count", 32'(cnt_m), 32'd0);
        chk("rst_ready", {bus_m.a_ready, bus_m.b_ready}, 2'b00);
        tick(); reset = 1'b0;
        smp();
        chk("idle_no_valid", {busy_m, bus_m.cw_valid, bus_m.a_ready, bus_m.b_ready}, 4'b0000);

        // Single A byte 8'hA5
        tick(); bus_m.a_data = 8'hA5; bus_m.a_valid = 1'b1;
        smp(); chk("t1_ready", {bus_m.b_ready, bus_m.a_ready}, 2'b01);
        tick(); bus_m.a_valid = 1'b0;
        smp(); chk("t1_hi", {bus_m.cw_valid, bus_m.cw_src, bus_m.cw_last, bus_m.cw_data, busy_m},
                   {3'b100, 8'h8C, 1'b1});
        tick(); smp();
        chk("t1_lo", {bus_m.cw_valid, bus_m.cw_last, bus_m.cw_data}, {2'b11, 8'h73});
        tick(); smp();
        chk("t1_idle", {bus_m.cw_valid, busy_m}, 2'b00);
        chk("t1_count", 32'(cnt_m), 32'd2);

        // Contention: A=0F, B=3C both held valid, A wins first after reset
        do_reset();
        bus_m.a_data = 8'h0F; bus_m.a_valid = 1'b1;
        bus_m.b_data = 8'h3C; bus_m.b_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            smp();
            chk($sformatf("t2_ready_c%0d", i), {bus_m.b_ready, bus_m.a_ready}, er[i]);
            if (i >= 1) chk($sformatf("t2_nobubble_c%0d", i), bus_m.cw_valid, 1'b1);
            if (i == 3) chk("t2_b_hi", {bus_m.cw_src, bus_m.cw_data}, {1'b1, 8'h5E});
            tick();
            if (i == 4) begin
                bus_m.a_valid = 1'b0;
                bus_m.b_valid = 1'b0;
            end
        end
        smp(); chk("t2_idle", {bus_m.cw_valid, busy_m}, 2'b00);

        // Back-pressure: 8'h3C from A stalled 5 cycles on its high codeword
        tick(); bus_m.a_data = 8'h3C; bus_m.a_valid = 1'b1;
        smp(); chk("t3_ready", {bus_m.b_ready, bus_m.a_ready}, 2'b01);
        tick(); bus_m.a_valid = 1'b0; bus_m.cw_ready = 1'b0;
        bus_m.b_data = 8'h55; bus_m.b_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            smp();
            chk($sformatf("t3_stall_c%0d", k),
                {bus_m.cw_valid, bus_m.cw_data, bus_m.a_ready, bus_m.b_ready}, {1'b1, 8'h5E, 2'b00});
            tick();
        end
        bus_m.cw_ready = 1'b1;
        smp(); chk("t3_release", {bus_m.cw_valid, bus_m.cw_last, bus_m.cw_data}, {2'b10, 8'h5E});
        tick(); smp();
        chk("t3_lo", {bus_m.cw_last, bus_m.cw_data, bus_m.b_ready}, {1'b1, 8'hA1, 1'b1});
        tick(); bus_m.b_valid = 1'b0;
        smp(); chk("t3_b_hi", {bus_m.cw_src, bus_m.cw_data}, {1'b1, 8'h73});
        tick(); smp(); tick(); smp();
        chk("t3_idle", busy_m, 1'b0);

        // Only B, twice in a row, while last grant is already B
        tick(); bus_m.b_data = 8'h01; bus_m.b_valid = 1'b1;
        smp(); chk("t4_ready0", {bus_m.b_ready, bus_m.a_ready}, 2'b10);
        tick(); bus_m.b_data = 8'hF0;
        smp(); chk("t4_hi0", {bus_m.cw_src, bus_m.cw_data, bus_m.b_ready}, {1'b1, 8'h15, 1'b0});
        tick(); smp();
        chk("t4_lo0_take", {bus_m.cw_data, bus_m.b_ready}, {8'h02, 1'b1});
        tick(); bus_m.b_valid = 1'b0;
        smp(); chk("t4_hi1", {bus_m.cw_src, bus_m.cw_last, bus_m.cw_data}, {2'b10, 8'hEA});
        tick(); smp(); chk("t4_lo1", {bus_m.cw_last, bus_m.cw_data}, {1'b1, 8'h15});
        tick(); smp(); chk("t4_idle", busy_m, 1'b0);

        // Reset while SEND_LO is stalled
        tick(); bus_m.a_data = 8'h12; bus_m.a_valid = 1'b1;
        smp(); chk("t5_ready", bus_m.a_ready, 1'b1);
        tick(); bus_m.a_valid = 1'b0;
        smp();
        tick(); bus_m.cw_ready = 1'b0;
        smp(); chk("t5_lo_stalled", {bus_m.cw_valid, bus_m.cw_last}, 2'b11);
        tick(); reset = 1'b1; bus_m.cw_ready = 1'b1; bus_m.a_data = 8'h77; bus_m.a_valid = 1'b1;
        smp(); chk("t5_rst_noready", {bus_m.a_ready, bus_m.b_ready}, 2'b00);
        tick(); reset = 1'b0; bus_m.a_valid = 1'b0;
        smp();
        chk("t5_after_rst", {bus_m.cw_valid, busy_m, bus_m.a_ready, bus_m.b_ready}, 4'b0000);
        chk("t5_count_clr", 32'(cnt_m), 32'd0);
        tick(); bus_m.a_valid = 1'b1;
        smp(); chk("t5_next_ready", bus_m.a_ready, 1'b1);
        tick(); bus_m.a_valid = 1'b0;
        smp(); chk("t5_next_hi", {bus_m.cw_src, bus_m.cw_last, bus_m.cw_data}, {2'b00, 8'h2F});
        tick(); smp(); tick(); smp();
        chk("t5_count", 32'(cnt_m), 32'd2);

        // Counter wrap on the 2-bit instance: 3 bytes, 6 handshakes
        do_reset();
        bus_m.a_data = 8'hC3; bus_m.a_valid = 1'b1;
        smp(); chk("t6_take0", bus_m.a_ready, 1'b1);
        tick(); bus_m.a_data = 8'h5A;
        smp(); tick(); smp();
        chk("t6_take1", bus_m.a_ready, 1'b1);
        tick(); bus_m.a_data = 8'hFF;
        smp(); tick(); smp();
        chk("t6_take2", bus_m.a_ready, 1'b1);
        chk("t6_small_3", 32'(cnt_s), 32'd3);
        tick(); bus_m.a_valid = 1'b0;
        smp(); chk("t6_small_wrap", 32'(cnt_s), 32'd0);
        chk("t6_main_4", 32'(cnt_m), 32'd4);
        tick(); smp(); tick(); smp();
        chk("t6_small_end", 32'(cnt_s), 32'd2);
        chk("t6_main_end", 32'(cnt_m), 32'd6);

        tick(); smp();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
